// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and parity selection constants.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: frames one word as start, LSB-first data, optional parity and stop bits.
// Bit timing comes from an external phase accumulator held in reset while the line is idle.
module uart_tx #(
    parameter int UART_SIZE = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    output logic                 phase_accum_reset,
    input  logic [UART_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_enable,
    input  logic                 parity_type,
    input  logic                 CTS,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 TX
);
    import uart_pkg::*;

    localparam int                 CNT_W     = $clog2(UART_SIZE) + 1;
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(UART_SIZE - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t            state;
    uart_state_t            next_state;
    logic [UART_SIZE-1:0]   shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   stop_cnt;
    logic                   parity_en_q;
    logic                   parity_bit;
    logic                   ready_en;
    logic                   tx_reg;
    logic                   tx_next;
    logic                   done_reg;
    logic                   done_next;
    logic                   accept;

    // ready_en keeps tx_ready low through the first edge after reset releases
    assign tx_ready          = ready_en && (state == IDLE) && CTS;
    assign accept            = tx_valid && tx_ready;
    assign tx_busy           = (state != IDLE);
    assign phase_accum_reset = (state == IDLE);
    assign tx_done           = done_reg;
    assign TX                = tx_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            state    <= next_state;
            tx_reg   <= tx_next;
            done_reg <= done_next;
            ready_en <= 1'b1;
        end
    end

    // tx_next is the line level for the state being entered, so TX stays a pure register
    always_comb begin
        next_state = state;
        tx_next    = 1'b1;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_tick) begin
                    next_state = DATA;
                    tx_next    = shift_reg[0];
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (baud_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (parity_en_q) begin
                            next_state = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            next_state = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        tx_next = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                tx_next = parity_bit;
                if (baud_tick) begin
                    next_state = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (baud_tick && (stop_cnt == LAST_STOP)) begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Parity is resolved at accept time so only one bit has to be held for the frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            parity_en_q <= 1'b0;
            parity_bit  <= 1'b0;
        end else if (accept) begin
            shift_reg   <= tx_data;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            parity_en_q <= parity_enable;
            parity_bit  <= (^tx_data) ^ (parity_type == PARITY_ODD);
        end else if (baud_tick) begin
            if (state == DATA) begin
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt + CNT_W'(1);
            end
            if (state == STOP) begin
                stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

endmodule
